// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and helpers for the 7-segment scan driver
//   SEG_BLANK  pattern with all segments off (active-low)
//   SEG_TABLE  hex nibble -> {g,f,e,d,c,b,a}, active-low, entry 0 at the LSB end
//   idx_width  width of an index/counter over n states, never below 1
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to active-low 7-segment pattern
//   nib_i  hex digit 0..F
//   seg_o  segments {g,f,e,d,c,b,a}, active-low
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed common-anode 7-segment driver with tear-free loads
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   load                        strobe capturing value_in/dp_in/blink_en/blank_lz
//   value_in                    hex nibbles, digit i = [4i+3:4i], digit 0 rightmost
//   dp_in, blink_en             per-digit decimal point and blink enable
//   blank_lz                    blank leading zero digits
//   seg_out, dp_out, an_out     active-low segments, decimal point and anodes
//   frame_start                 1-cycle pulse as the digit 0 slot begins
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD_CYC    = 1,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    blank_lz,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_start
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = idx_width(NUM_DIGITS);
    localparam int BW = idx_width(BLINK_FRAMES);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] GUARD      = SW'(GUARD_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [SW-1:0]           slot_q, slot_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [BW-1:0]           bcnt_q, bcnt_d;
    logic                    phase_q, phase_d;
    logic                    pval_q, pval_d;
    logic [4*NUM_DIGITS-1:0] pv_q, pv_d, av_q, av_d;
    logic [NUM_DIGITS-1:0]   pdp_q, pdp_d, adp_q, adp_d;
    logic [NUM_DIGITS-1:0]   pbl_q, pbl_d, abl_q, abl_d;
    logic                    plz_q, plz_d, alz_q, alz_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fs_q, fs_d;
    logic                    slot_end, wrap, lz, bb;
    logic [3:0]              nib;
    logic [6:0]              dec;

    seg_hex_decode u_dec (
        .nib_i (nib),
        .seg_o (dec)
    );

    always_comb begin
        slot_end = slot_q == SLOT_LAST;
        wrap     = slot_end && idx_q == IDX_LAST;
        slot_d   = slot_end ? '0 : slot_q + 1'b1;
        idx_d    = wrap ? '0 : slot_end ? idx_q + 1'b1 : idx_q;
        bcnt_d   = wrap ? ((bcnt_q == BLINK_LAST) ? '0 : bcnt_q + 1'b1) : bcnt_q;
        phase_d  = phase_q ^ (wrap && bcnt_q == BLINK_LAST);
        // A load in the wrap cycle bypasses pending so it shows from this frame's digit 0.
        pval_d   = !wrap && (load || pval_q);
        pv_d     = load ? value_in : pv_q;
        pdp_d    = load ? dp_in    : pdp_q;
        pbl_d    = load ? blink_en : pbl_q;
        plz_d    = load ? blank_lz : plz_q;
        av_d     = (wrap && load) ? value_in : (wrap && pval_q) ? pv_q  : av_q;
        adp_d    = (wrap && load) ? dp_in    : (wrap && pval_q) ? pdp_q : adp_q;
        abl_d    = (wrap && load) ? blink_en : (wrap && pval_q) ? pbl_q : abl_q;
        alz_d    = (wrap && load) ? blank_lz : (wrap && pval_q) ? plz_q : alz_q;
        nib      = 4'(av_q >> {idx_q, 2'b00});
        // Leading zero: this nibble and every one above it are zero; digit 0 always shows.
        lz       = alz_q && idx_q != '0 && (av_q >> {idx_q, 2'b00}) == '0;
        bb       = abl_q[idx_q] && phase_q;
        seg_d    = (lz || bb) ? SEG_BLANK : dec;
        dp_d     = !(adp_q[idx_q] && !bb);
        an_d     = (slot_q < GUARD) ? '1 : ~(NUM_DIGITS'(1) << idx_q);
        fs_d     = slot_q == '0 && idx_q == '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q  <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            pval_q  <= 1'b0;
            pv_q    <= '0;
            pdp_q   <= '0;
            pbl_q   <= '0;
            plz_q   <= 1'b0;
            av_q    <= '0;
            adp_q   <= '0;
            abl_q   <= '0;
            alz_q   <= 1'b0;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            an_q    <= '1;
            fs_q    <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            pval_q  <= pval_d;
            pv_q    <= pv_d;
            pdp_q   <= pdp_d;
            pbl_q   <= pbl_d;
            plz_q   <= plz_d;
            av_q    <= av_d;
            adp_q   <= adp_d;
            abl_q   <= abl_d;
            alz_q   <= alz_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            fs_q    <= fs_d;
        end
    end

    assign seg_out     = seg_q;
    assign dp_out      = dp_q;
    assign an_out      = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed self-checking bench for seg_scan_display (4 digits, 4-cycle slots)
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_en = '0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_start;

    int total = 0;
    int bad = 0;

    logic [6:0]  seg_c [16];
    logic [3:0]  an_c [16];
    logic        dp_c [16];
    logic        timed_out;
    // Expected anodes for samples 0..15 of a frame, sample 0 at the LSB nibble.
    logic [63:0] an_tbl = 64'h777F_BBBF_DDDF_EEEF;

    seg_scan_display #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (4),
        .GUARD_CYC    (1),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value_in    (value_in),
        .dp_in       (dp_in),
        .blink_en    (blink_en),
        .blank_lz    (blank_lz),
        .seg_out     (seg_out),
        .dp_out      (dp_out),
        .an_out      (an_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Records the 16 output samples of the next frame, sample 0 being the frame_start cycle.
    // Optional loads are raised right after samples la/lb so they hit the following edge.
    task automatic capture_frame(input int la, input logic [15:0] va, input int lb, input logic [15:0] vb);
        timed_out = 1'b1;
        for (int k = 0; k < 40 && timed_out; k++) begin
            tick();
            if (frame_start) timed_out = 1'b0;
        end
        for (int j = 0; j < 16; j++) begin
            if (j > 0) tick();
            seg_c[j] = seg_out;
            an_c[j]  = an_out;
            dp_c[j]  = dp_out;
            load = (j == la) || (j == lb);
            if (j == la) value_in = va;
            if (j == lb) value_in = vb;
        end
        load = 1'b0;
    endtask

    task automatic load_now(input logic [15:0] v);
        value_in = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (seg_out !== 7'h7F || an_out !== 4'hF || dp_out !== 1'b1 || frame_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_state seg=%h an=%h dp=%b fs=%b want 7f f 1 0", seg_out, an_out, dp_out, frame_start);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        total++;
        if (frame_start !== 1'b1 || an_out !== 4'hF) begin
            bad++;
            $display("FAIL release_first fs=%b an=%h want 1 f", frame_start, an_out);
        end
        tick();
        total++;
        if (frame_start !== 1'b0 || an_out !== 4'hE || seg_out !== 7'h40) begin
            bad++;
            $display("FAIL release_digit0 fs=%b an=%h seg=%h want 0 e 40", frame_start, an_out, seg_out);
        end
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (seg_out !== 7'h7F || an_out !== 4'hF || dp_out !== 1'b1 || frame_start !== 1'b0) begin
            bad++;
            $display("FAIL midframe_reset seg=%h an=%h dp=%b fs=%b want 7f f 1 0", seg_out, an_out, dp_out, frame_start);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        total++;
        if (frame_start !== 1'b1 || an_out !== 4'hF) begin
            bad++;
            $display("FAIL restart_first fs=%b an=%h want 1 f", frame_start, an_out);
        end
        tick();
        total++;
        if (an_out !== 4'hE) begin
            bad++;
            $display("FAIL restart_idx0 an=%h want e", an_out);
        end
    endtask

    task automatic test_scan;
        logic [27:0] e;
        load_now(16'h1234);
        capture_frame(-1, '0, -1, '0);
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL scan_fs_timeout got no frame_start want pulse");
        end
        for (int j = 0; j < 16; j++) begin
            total++;
            if (an_c[j] !== an_tbl[4*j +: 4]) begin
                bad++;
                $display("FAIL scan_an[%0d] got %h want %h", j, an_c[j], an_tbl[4*j +: 4]);
            end
        end
        e = {7'h79, 7'h24, 7'h30, 7'h19};
        for (int d = 0; d < 4; d++)
            for (int s = 1; s < 4; s++) begin
                total++;
                if (seg_c[4*d+s] !== e[7*d +: 7] || dp_c[4*d+s] !== 1'b1) begin
                    bad++;
                    $display("FAIL scan_seg d%0d got %h/%b want %h/1", d, seg_c[4*d+s], dp_c[4*d+s], e[7*d +: 7]);
                end
            end
    endtask

    task automatic test_tear_free;
        logic [27:0] e;
        capture_frame(5, 16'hABCD, -1, '0);
        e = {7'h79, 7'h24, 7'h30, 7'h19};
        for (int j = 6; j < 16; j++) begin
            total++;
            if (j % 4 != 0 && seg_c[j] !== e[7*(j/4) +: 7]) begin
                bad++;
                $display("FAIL tear_old s%0d got %h want %h", j, seg_c[j], e[7*(j/4) +: 7]);
            end
        end
        capture_frame(-1, '0, -1, '0);
        e = {7'h08, 7'h03, 7'h46, 7'h21};
        for (int d = 0; d < 4; d++) begin
            total++;
            if (seg_c[4*d+1] !== e[7*d +: 7] || an_c[4*d+1] !== an_tbl[16*d+4 +: 4]) begin
                bad++;
                $display("FAIL tear_new d%0d got %h an %h want %h", d, seg_c[4*d+1], an_c[4*d+1], e[7*d +: 7]);
            end
        end
    endtask

    task automatic test_boundary_load;
        logic [27:0] e;
        capture_frame(14, 16'h5678, -1, '0);
        total++;
        if (seg_c[15] !== 7'h08) begin
            bad++;
            $display("FAIL boundary_old got %h want 08", seg_c[15]);
        end
        capture_frame(-1, '0, -1, '0);
        e = {7'h12, 7'h02, 7'h78, 7'h00};
        for (int d = 0; d < 4; d++) begin
            total++;
            if (seg_c[4*d+1] !== e[7*d +: 7]) begin
                bad++;
                $display("FAIL boundary_new d%0d got %h want %h", d, seg_c[4*d+1], e[7*d +: 7]);
            end
        end
    endtask

    task automatic test_last_load_wins;
        logic [27:0] e;
        capture_frame(3, 16'h0F0F, 9, 16'hE0C3);
        capture_frame(5, 16'h1111, 14, 16'h2468);
        e = {7'h06, 7'h40, 7'h46, 7'h30};
        for (int d = 0; d < 4; d++) begin
            total++;
            if (seg_c[4*d+1] !== e[7*d +: 7]) begin
                bad++;
                $display("FAIL last_wins d%0d got %h want %h", d, seg_c[4*d+1], e[7*d +: 7]);
            end
        end
        capture_frame(-1, '0, -1, '0);
        e = {7'h24, 7'h19, 7'h02, 7'h00};
        for (int d = 0; d < 4; d++) begin
            total++;
            if (seg_c[4*d+1] !== e[7*d +: 7]) begin
                bad++;
                $display("FAIL boundary_over_pending d%0d got %h want %h", d, seg_c[4*d+1], e[7*d +: 7]);
            end
        end
    endtask

    task automatic test_leading_zero;
        logic [27:0] e;
        blank_lz = 1'b1;
        dp_in = 4'b1000;
        load_now(16'h0050);
        capture_frame(-1, '0, -1, '0);
        e = {7'h7F, 7'h7F, 7'h12, 7'h40};
        for (int d = 0; d < 4; d++) begin
            total++;
            if (seg_c[4*d+1] !== e[7*d +: 7]) begin
                bad++;
                $display("FAIL lz_0050 d%0d got %h want %h", d, seg_c[4*d+1], e[7*d +: 7]);
            end
        end
        for (int j = 0; j < 16; j++) begin
            total++;
            if (dp_c[j] !== (j < 12)) begin
                bad++;
                $display("FAIL lz_dp s%0d got %b want %b", j, dp_c[j], j < 12);
            end
        end
        load_now(16'h0000);
        capture_frame(-1, '0, -1, '0);
        e = {7'h7F, 7'h7F, 7'h7F, 7'h40};
        for (int d = 0; d < 4; d++) begin
            total++;
            if (seg_c[4*d+1] !== e[7*d +: 7]) begin
                bad++;
                $display("FAIL lz_0000 d%0d got %h want %h", d, seg_c[4*d+1], e[7*d +: 7]);
            end
        end
        load_now(16'h1000);
        capture_frame(-1, '0, -1, '0);
        e = {7'h79, 7'h40, 7'h40, 7'h40};
        for (int d = 0; d < 4; d++) begin
            total++;
            if (seg_c[4*d+1] !== e[7*d +: 7]) begin
                bad++;
                $display("FAIL lz_1000 d%0d got %h want %h", d, seg_c[4*d+1], e[7*d +: 7]);
            end
        end
        blank_lz = 1'b0;
        dp_in = 4'b0000;
    endtask

    task automatic test_blink_dp;
        logic [27:0] e0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        blink_en = 4'b0001;
        dp_in = 4'b0010;
        blank_lz = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        load_now(16'h1234);
        // Digit 0 per frame 1..4 after reset: phase flips after every second frame.
        e0 = {7'h19, 7'h7F, 7'h7F, 7'h19};
        for (int f = 0; f < 4; f++) begin
            capture_frame(-1, '0, -1, '0);
            total++;
            if (seg_c[1] !== e0[7*f +: 7] || seg_c[5] !== 7'h30) begin
                bad++;
                $display("FAIL blink f%0d d0=%h d1=%h want %h 30", f + 1, seg_c[1], seg_c[5], e0[7*f +: 7]);
            end
            for (int j = 0; j < 16; j++) begin
                total++;
                if (dp_c[j] !== !(j >= 4 && j < 8)) begin
                    bad++;
                    $display("FAIL blink_dp f%0d s%0d got %b want %b", f + 1, j, dp_c[j], !(j >= 4 && j < 8));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_boundary_load();
        test_last_load_wins();
        test_leading_zero();
        test_blink_dp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
